exe_muldiv: RTL and testbench
=============================

# exe_muldiv

Execute-stage multiply/divide unit for the five-stage pipeline, sitting beside the ALU in EXE and owning the HI/LO register pair. It accepts one multiply, divide or HI/LO move per `start` pulse. Multiply and divide run for a fixed, parametrised number of cycles while `busy` stalls the pipeline. It is the width- and latency-parametrised successor of the single-cycle ALU path, adding multi-cycle operation, a flush and an optional multiply-accumulate mode.

## Interface
- `WIDTH`, 32, operand and HI/LO width.
- `MUL_CYCLES`, 5, busy cycles for multiply-class ops (≥1).
- `DIV_CYCLES`, 10, busy cycles for divide ops (≥1).

- `clk`  in  1  clock. One clock domain; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  launch the op on `md_op`; sampled on the rising edge.
- `md_op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
- `flush`  in  1  cancel the in-flight op (exception/interrupt).
- `E_A`  in  WIDTH  operand A (rs).
- `E_B`  in  WIDTH  operand B (rt).
- `busy`  out  1  multi-cycle op in progress; the pipeline stalls any HI/LO access while it is high.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- State machine: IDLE, MUL, DIV. Cycle counter width is clog2(max(MUL_CYCLES, DIV_CYCLES)) + 1.
- In IDLE, `start` causes:
  - MULT/MULTU/MADD/MSUB: latch `E_A`, `E_B` and `md_op`; load the counter with MUL_CYCLES; go to MUL.
  - DIV/DIVU: latch the same way; load the counter with DIV_CYCLES; go to DIV.
  - MTHI/MTLO: write `E_A` into `hi`/`lo` at that edge; stay in IDLE; `busy` stays low.
- In MUL or DIV, the counter decrements each cycle. At the cycle where it reaches zero, write the result into `hi`/`lo` and return to IDLE.
- `start` while not in IDLE is ignored. The pipeline guarantees this never happens; the bench checks that state is unaffected if it does.
- Arithmetic, all modulo 2^(2·WIDTH) for products:
  - MULT: signed; {hi,lo} = A·B.
  - MULTU: unsigned; {hi,lo} = A·B.
  - DIV: signed; lo = quotient truncated toward zero; hi = remainder, taking the sign of the dividend.
  - DIVU: unsigned; lo = quotient; hi = remainder.
  - Divide by zero: lo = all ones; hi = A.
  - Signed overflow, −2^(WIDTH−1) / −1: lo = −2^(WIDTH−1); hi = 0.
- Operands are latched at `start`, so later changes on `E_A`/`E_B` have no effect on the running op.
- `flush`:
  - In MUL/DIV: return to IDLE at that edge; `hi`/`lo` unchanged; `busy` low next cycle.
  - In IDLE: no effect.
  - Same edge as `start`: flush wins and the start is dropped, including MTHI/MTLO.
- Reset (`rst_n` low, at any time, including mid-operation): state IDLE, counter 0, `busy` 0, `hi` 0, `lo` 0, immediately and asynchronously.

## Timing
- If `start` is accepted at edge N for an op of latency L, `busy` is high from after edge N through edge N+L. At edge N+L `busy` falls and `hi`/`lo` show the result simultaneously.
- With MUL_CYCLES=1 a multiply is busy for exactly one cycle.
- A back-to-back `start` is accepted at edge N+L, the same edge `busy` falls, because state is IDLE at that edge.
- MTHI/MTLO take effect at the sampling edge; zero busy cycles.
- `busy` and `hi`/`lo` are registered outputs; there is no combinational path from inputs to outputs.

## Configuration
- `MD_MADD_EN` defined:
  - MADD: {hi,lo} ← {hi,lo} + signed(A·B).
  - MSUB: {hi,lo} ← {hi,lo} − signed(A·B).
  - Both use MUL_CYCLES latency. The {hi,lo} value read is the one held at completion.
- `MD_MADD_EN` undefined: codes 6 and 7 are no-ops; no `busy`, `hi`/`lo` unchanged, state stays IDLE.

## Test plan
- Reset, then MULT A=0xFFFFFFFE (−2), B=3 → `busy` high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV A=−7, B=2 → `busy` high for 10 cycles; then lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
- DIVU A=0x80000000, B=0 → lo=0xFFFFFFFF, hi=0x80000000.
- DIV A=0x80000000, B=0xFFFFFFFF → lo=0x80000000, hi=0.
- MULTU 0xFFFFFFFF×0xFFFFFFFF:
  - Assert `flush` on busy cycle 3 → hi/lo keep their prior values; `busy` low the next cycle.
  - Rerun the op, assert `rst_n` low mid-operation → hi=lo=0 and busy=0 immediately.
- With `MD_MADD_EN`: MTHI 0, MTLO 10, MADD 4×5 → lo=30, hi=0; then MSUB 8×5 → lo=0xFFFFFFF6, hi=0xFFFFFFFF.
- Without `MD_MADD_EN`: the same op-6 sequence → `busy` stays 0; hi/lo unchanged.

Source files
------------

// File: rtl/exe_muldiv_if.sv
// rtl/exe_muldiv_if.sv - pipeline-facing bundle of the EXE multiply/divide unit
interface exe_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       md_op;
  logic             flush;
  logic [WIDTH-1:0] E_A;
  logic [WIDTH-1:0] E_B;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, md_op, flush, E_A, E_B, input busy, hi, lo);
  modport slave  (input start, md_op, flush, E_A, E_B, output busy, hi, lo);
endinterface

// File: rtl/exe_muldiv.sv
// rtl/exe_muldiv.sv - multi-cycle multiply/divide unit owning HI/LO
// Optional MADD/MSUB accumulate ops are built when MD_MADD_EN is defined.
module exe_muldiv #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  exe_muldiv_if.slave  md
);
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam int W2   = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo;
  logic             r_busy;

  logic [W2-1:0]    w_prod_s, w_prod_u, w_mul_res;
  logic             w_neg_a, w_neg_b, w_b_zero, w_done, w_accept;
  logic [WIDTH-1:0] w_one, w_mag_a, w_mag_b, w_safe_b, w_safe_mag_b;
  logic [WIDTH-1:0] w_uq, w_ur, w_sq_mag, w_sr_mag, w_div_hi, w_div_lo;

  assign w_prod_s = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

  always_comb begin
    w_mul_res = w_prod_s;
    case (r_op)
      3'd1:    w_mul_res = w_prod_u;
`ifdef MD_MADD_EN
      3'd6:    w_mul_res = {r_hi, r_lo} + w_prod_s;
      3'd7:    w_mul_res = {r_hi, r_lo} - w_prod_s;
`endif
      default: w_mul_res = w_prod_s;
    endcase
  end

  // Signed divide works on magnitudes; -2^(W-1)/-1 then wraps to itself naturally.
  assign w_one        = {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_neg_a      = r_a[WIDTH-1];
  assign w_neg_b      = r_b[WIDTH-1];
  assign w_b_zero     = (r_b == '0);
  assign w_mag_a      = w_neg_a ? (~r_a + w_one) : r_a;
  assign w_mag_b      = w_neg_b ? (~r_b + w_one) : r_b;
  assign w_safe_b     = w_b_zero ? w_one : r_b;
  assign w_safe_mag_b = w_b_zero ? w_one : w_mag_b;
  assign w_uq         = r_a / w_safe_b;
  assign w_ur         = r_a % w_safe_b;
  assign w_sq_mag     = w_mag_a / w_safe_mag_b;
  assign w_sr_mag     = w_mag_a % w_safe_mag_b;

  always_comb begin
    w_div_hi = '0;
    w_div_lo = '0;
    if (w_b_zero) begin
      w_div_hi = r_a;
      w_div_lo = '1;
    end else if (r_op[0]) begin
      w_div_hi = w_ur;
      w_div_lo = w_uq;
    end else begin
      w_div_hi = w_neg_a ? (~w_sr_mag + w_one) : w_sr_mag;
      w_div_lo = (w_neg_a ^ w_neg_b) ? (~w_sq_mag + w_one) : w_sq_mag;
    end
  end

  // The completion edge already counts as idle, so a back-to-back start is taken there.
  assign w_done   = (r_state != S_IDLE) && (r_cnt == CW'(1));
  assign w_accept = md.start && !md.flush && ((r_state == S_IDLE) || w_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
    end else if (md.flush && (r_state != S_IDLE)) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      if (r_state != S_IDLE) begin
        if (w_done) begin
          if (r_state == S_MUL) begin
            {r_hi, r_lo} <= w_mul_res;
          end else begin
            r_hi <= w_div_hi;
            r_lo <= w_div_lo;
          end
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
      if (w_accept) begin
        case (md.md_op)
`ifdef MD_MADD_EN
          3'd0, 3'd1, 3'd6, 3'd7: begin
`else
          3'd0, 3'd1: begin
`endif
            r_op    <= md.md_op;
            r_a     <= md.E_A;
            r_b     <= md.E_B;
            r_cnt   <= CW'(MUL_CYCLES);
            r_state <= S_MUL;
            r_busy  <= 1'b1;
          end
          3'd2, 3'd3: begin
            r_op    <= md.md_op;
            r_a     <= md.E_A;
            r_b     <= md.E_B;
            r_cnt   <= CW'(DIV_CYCLES);
            r_state <= S_DIV;
            r_busy  <= 1'b1;
          end
          3'd4:    r_hi <= md.E_A;
          3'd5:    r_lo <= md.E_A;
          default: ;
        endcase
      end
    end
  end

  assign md.busy = r_busy;
  assign md.hi   = r_hi;
  assign md.lo   = r_lo;
endmodule

// File: tb/tb_exe_muldiv.sv
// tb/tb_exe_muldiv.sv - self-checking bench for exe_muldiv
module tb_exe_muldiv;
  localparam int ML = 5;
  localparam int DL = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  exe_muldiv_if #(.WIDTH(32)) mif ();
  exe_muldiv #(.WIDTH(32), .MUL_CYCLES(ML), .DIV_CYCLES(DL)) dut (.clk(clk), .rst_n(rst_n), .md(mif));

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;
  vec_t tv[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    mif.start = 1'b1; mif.md_op = op; mif.E_A = a; mif.E_B = b;
    @(negedge clk);
    mif.start = 1'b0; mif.E_A = $urandom; mif.E_B = $urandom; mif.md_op = 3'($urandom);
    lat = 0;
    while (mif.busy && lat < 50) begin
      lat++;
      @(negedge clk);
    end
  endtask

  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] hi, inout logic [31:0] lo, output int lat);
    logic [63:0] p;
    longint      q, r;
    lat = 0;
    case (op)
      3'd0: begin p = 64'(longint'($signed(a)) * longint'($signed(b))); {hi, lo} = p; lat = ML; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; {hi, lo} = p; lat = ML; end
      3'd2, 3'd3: begin
        lat = DL;
        if (b == 0) begin
          lo = '1; hi = a;
        end else if (op == 3'd2) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          lo = q[31:0]; hi = r[31:0];
        end else begin
          lo = a / b; hi = a % b;
        end
      end
      3'd4: hi = a;
      3'd5: lo = a;
      default: begin
`ifdef MD_MADD_EN
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        {hi, lo} = (op == 3'd6) ? ({hi, lo} + p) : ({hi, lo} - p);
        lat = ML;
`endif
      end
    endcase
  endfunction

  initial begin
    int lat, elat;
    logic [31:0] mhi, mlo, ra, rb, hold_hi, hold_lo;
    logic [2:0]  rop;

    tv[0] = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, ML};
    tv[1] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DL};
    tv[2] = '{3'd3, 32'h80000000, 32'd0,        32'h80000000, 32'hFFFFFFFF, DL};
    tv[3] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DL};
    tv[4] = '{3'd2, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, DL};
    tv[5] = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       DL};
    tv[6] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DL};
    tv[7] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, ML};
    tv[8] = '{3'd4, 32'h12345678, 32'd0,        32'h12345678, 32'h00000001, 0};
    tv[9] = '{3'd5, 32'h9ABCDEF0, 32'd0,        32'h12345678, 32'h9ABCDEF0, 0};

    mif.start = 1'b0; mif.md_op = '0; mif.flush = 1'b0; mif.E_A = '0; mif.E_B = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset busy", 64'(mif.busy), 64'd0);
    chk("reset hi", 64'(mif.hi), 64'd0);
    chk("reset lo", 64'(mif.lo), 64'd0);

    for (int i = 0; i < 10; i++) begin
      do_op(tv[i].op, tv[i].a, tv[i].b, lat);
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'(tv[i].lat));
      chk($sformatf("vec%0d hi", i), 64'(mif.hi), 64'(tv[i].hi));
      chk($sformatf("vec%0d lo", i), 64'(mif.lo), 64'(tv[i].lo));
    end

    // flush on busy cycle 3 of a MULTU
    @(negedge clk);
    mif.start = 1'b1; mif.md_op = 3'd1; mif.E_A = '1; mif.E_B = '1;
    @(negedge clk); mif.start = 1'b0;
    @(negedge clk);
    @(negedge clk); mif.flush = 1'b1;
    @(negedge clk); mif.flush = 1'b0;
    chk("flush busy", 64'(mif.busy), 64'd0);
    chk("flush hi", 64'(mif.hi), 64'h12345678);
    chk("flush lo", 64'(mif.lo), 64'h9ABCDEF0);
    repeat (ML) @(negedge clk);
    chk("flush no late write", {mif.hi, mif.lo}, 64'h12345678_9ABCDEF0);

    mif.flush = 1'b1;
    @(negedge clk); mif.flush = 1'b0;
    chk("idle flush", {31'd0, mif.busy, mif.hi}, 64'h12345678);
    mif.start = 1'b1; mif.flush = 1'b1; mif.md_op = 3'd4; mif.E_A = 32'hDEAD;
    @(negedge clk);
    mif.md_op = 3'd2;
    @(negedge clk); mif.start = 1'b0; mif.flush = 1'b0;
    chk("flush+start busy", 64'(mif.busy), 64'd0);
    chk("flush+start hi", 64'(mif.hi), 64'h12345678);

    // start during a divide must be ignored
    mif.start = 1'b1; mif.md_op = 3'd2; mif.E_A = 32'd100; mif.E_B = 32'd7;
    @(negedge clk); mif.start = 1'b0;
    @(negedge clk); mif.start = 1'b1; mif.md_op = 3'd4; mif.E_A = 32'hAAAA;
    @(negedge clk); mif.start = 1'b0;
    lat = 2;
    while (mif.busy && lat < 50) begin
      lat++;
      @(negedge clk);
    end
    chk("ignored start latency", 64'(lat), 64'(DL));
    chk("ignored start result", {mif.hi, mif.lo}, {32'd2, 32'd14});

    // back-to-back start on the completion edge
    mif.start = 1'b1; mif.md_op = 3'd0; mif.E_A = 32'd6; mif.E_B = 32'd7;
    @(negedge clk); mif.start = 1'b0;
    repeat (ML - 1) @(negedge clk);
    chk("b2b last cycle busy", 64'(mif.busy), 64'd1);
    mif.start = 1'b1; mif.md_op = 3'd1; mif.E_A = 32'd3; mif.E_B = 32'd5;
    @(negedge clk); mif.start = 1'b0;
    chk("b2b first result", {mif.hi, mif.lo}, 64'd42);
    lat = 0;
    while (mif.busy && lat < 50) begin
      lat++;
      @(negedge clk);
    end
    chk("b2b second latency", 64'(lat), 64'(ML));
    chk("b2b second result", {mif.hi, mif.lo}, 64'd15);

    // op 6/7 sequence
    do_op(3'd4, 32'd0, 32'd0, lat);
    do_op(3'd5, 32'd10, 32'd0, lat);
    do_op(3'd6, 32'd4, 32'd5, lat);
`ifdef MD_MADD_EN
    chk("madd latency", 64'(lat), 64'(ML));
    chk("madd result", {mif.hi, mif.lo}, 64'd30);
    do_op(3'd7, 32'd8, 32'd5, lat);
    chk("msub latency", 64'(lat), 64'(ML));
    chk("msub result", {mif.hi, mif.lo}, 64'hFFFFFFFF_FFFFFFF6);
`else
    chk("op6 no busy", 64'(lat), 64'd0);
    chk("op6 no change", {mif.hi, mif.lo}, 64'd10);
`endif

    // asynchronous reset mid-operation
    mif.start = 1'b1; mif.md_op = 3'd1; mif.E_A = '1; mif.E_B = '1;
    @(negedge clk); mif.start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy", 64'(mif.busy), 64'd0);
    chk("async reset hilo", {mif.hi, mif.lo}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (ML + 1) @(negedge clk);
    chk("post reset idle", {31'd0, mif.busy, mif.lo}, 64'd0);

    // randomized ops against the arithmetic model
    mhi = '0; mlo = '0;
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h80000000; rb = '1; end
        2: rb = '1;
        3: ra = '1;
        default: ;
      endcase
      hold_hi = mhi; hold_lo = mlo;
      model(rop, ra, rb, mhi, mlo, elat);
      do_op(rop, ra, rb, lat);
      chk($sformatf("rand%0d op%0d latency", i, rop), 64'(lat), 64'(elat));
      chk($sformatf("rand%0d op%0d a=%h b=%h prior=%h_%h", i, rop, ra, rb, hold_hi, hold_lo),
          {mif.hi, mif.lo}, {mhi, mlo});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
